// File: rtl/npu_pkg.sv
// npu_pkg: shared state type and sizes for the partial-sum accumulation buffer.
package npu_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAIN} psum_state_e;
    localparam int PSUM_DEPTH  = 132;
    localparam int PSUM_DATA_W = 24;
    localparam int PSUM_OUT_W  = 8;
    localparam int PSUM_ADDR_W = 8;
endpackage

// File: rtl/psum_accum_buf_if.sv
// psum_accum_buf_if: pixel write port, drain stream and status of the partial-sum buffer.
interface psum_accum_buf_if #(
    parameter int DATA_W = npu_pkg::PSUM_DATA_W,
    parameter int OUT_W  = npu_pkg::PSUM_OUT_W,
    parameter int ADDR_W = npu_pkg::PSUM_ADDR_W
);
    logic                     clear;
    logic                     ce;
    logic                     in_valid;
    logic [ADDR_W-1:0]        in_addr;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_start;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_last;
    logic                     drain_done;
    logic                     busy;
    logic                     ovf;
    logic                     err;
    modport master (
        output clear, ce, in_valid, in_addr, in_data, out_start, out_ready,
        input  out_valid, out_data, out_last, drain_done, busy, ovf, err
    );
    modport slave (
        input  clear, ce, in_valid, in_addr, in_data, out_start, out_ready,
        output out_valid, out_data, out_last, drain_done, busy, ovf, err
    );
endinterface

// File: rtl/psum_relu_q.sv
// psum_relu_q: ReLU then quantise to OUT_W bits; PSUM_SAT_EN clamps instead of truncating.
module psum_relu_q #(
    parameter int DATA_W = 24,
    parameter int OUT_W  = 8
) (
    input  logic signed [DATA_W-1:0] x_i,
    output logic [OUT_W-1:0]         y_o
);
`ifdef PSUM_SAT_EN
    assign y_o = x_i[DATA_W-1] ? '0 : (|x_i[DATA_W-2:OUT_W]) ? '1 : x_i[OUT_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = |x_i[DATA_W-2:OUT_W];
    assign y_o = x_i[DATA_W-1] ? '0 : x_i[OUT_W-1:0];
`endif
endmodule

// File: rtl/psum_accum_buf.sv
// psum_accum_buf: partial-sum buffer with saturating accumulate, self-clearing sweep and ReLU drain stream.
// Build option PSUM_SAT_EN (see psum_relu_q) selects output clamping over truncation.
module psum_accum_buf
    import npu_pkg::*;
#(
    parameter int DATA_W = PSUM_DATA_W,
    parameter int OUT_W  = PSUM_OUT_W,
    parameter int DEPTH  = PSUM_DEPTH,
    parameter int ADDR_W = PSUM_ADDR_W
) (
    input logic             clk,
    input logic             rst,
    psum_accum_buf_if.slave bus
);
    localparam logic [ADDR_W:0]          DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]        LAST    = ADDR_W'(DEPTH - 1);
    localparam logic signed [DATA_W-1:0] MAX_V   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V   = {1'b1, {(DATA_W-1){1'b0}}};

    psum_state_e              state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d, waddr;
    logic                     ovf_q, ovf_d, err_q, err_d, done_q, done_d;
    logic                     we, in_ok, sat, hs;
    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic signed [DATA_W-1:0] cur, acc, wdata;
    logic signed [DATA_W:0]   sum;
    logic [OUT_W-1:0]         qv;

    assign in_ok = {1'b0, bus.in_addr} < DEPTH_X;
    assign cur   = mem_q[bus.in_addr];
    assign sum   = {cur[DATA_W-1], cur} + {bus.in_data[DATA_W-1], bus.in_data};
    assign sat   = sum[DATA_W] ^ sum[DATA_W-1];
    assign acc   = sat ? (sum[DATA_W] ? MIN_V : MAX_V) : sum[DATA_W-1:0];
    assign hs    = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q | (bus.in_valid & (~in_ok | (state_q != S_IDLE)));
        we      = 1'b0;
        waddr   = bus.in_addr;
        wdata   = bus.ce ? acc : bus.in_data;
        case (state_q)
            S_CLEAR: begin
                we      = 1'b1;
                waddr   = idx_q;
                wdata   = '0;
                state_d = (idx_q == LAST) ? S_IDLE : S_CLEAR;
                idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            end
            S_IDLE: begin
                we      = bus.in_valid & in_ok;
                ovf_d   = ovf_q | (we & bus.ce & sat);
                state_d = bus.out_start ? S_DRAIN : S_IDLE;
                idx_d   = '0;
            end
            S_DRAIN: begin
                state_d = (hs && idx_q == LAST) ? S_IDLE : S_DRAIN;
                done_d  = hs && idx_q == LAST;
                idx_d   = hs ? ((idx_q == LAST) ? '0 : idx_q + 1'b1) : idx_q;
            end
            default: state_d = S_CLEAR;
        endcase
        // clear wins over every other transition, including a final drain handshake
        if (bus.clear) begin
            state_d = S_CLEAR;
            idx_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) mem_q[waddr] <= wdata;
    end

    psum_relu_q #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_q (.x_i(mem_q[idx_q]), .y_o(qv));

    assign bus.out_valid  = state_q == S_DRAIN;
    assign bus.out_data   = bus.out_valid ? qv : '0;
    assign bus.out_last   = bus.out_valid && idx_q == LAST;
    assign bus.drain_done = done_q;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.ovf        = ovf_q;
    assign bus.err        = err_q;
endmodule

// File: doc/psum_accum_buf.md
# psum_accum_buf

Partial-sum accumulation buffer between the convolution engine and the fully-connected engine. Accepts per-pixel 24-bit signed convolution results by address, either overwriting (first input channel) or accumulating (later channels) with signed saturation. On request it streams the ReLU-quantised 8-bit feature vector to the FC stage over a valid/ready handshake. Owns its own clear sweep, so contents are deterministic after reset or a host clear.

## Interface
Parameters:
- DATA_W, 24, signed accumulator and input width
- OUT_W, 8, unsigned output element width
- DEPTH, 132, number of entries (OUT2_H*OUT2_W)
- ADDR_W, 8, address width; DEPTH <= 2**ADDR_W

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- clear  in  1  pulse: start zeroing sweep
- ce  in  1  0 = overwrite entry, 1 = accumulate onto entry
- in_valid  in  1  input pixel strobe
- in_addr  in  ADDR_W  entry index
- in_data  in  DATA_W  signed pixel value
- out_start  in  1  pulse: start streaming the vector
- out_valid  out  1  stream element valid
- out_ready  in  1  consumer accepts element
- out_data  out  OUT_W  quantised element
- out_last  out  1  marks element DEPTH-1
- drain_done  out  1  one-cycle pulse after the last handshake
- busy  out  1  high in S_CLEAR or S_DRAIN
- ovf  out  1  sticky: saturation occurred
- err  out  1  sticky: input dropped

## Operation
- Storage: DEPTH x DATA_W register array, not reset; combinational read, write at the clock edge.
- FSM states: S_IDLE, S_CLEAR, S_DRAIN. A single index counter `idx` (ADDR_W bits) is shared by S_CLEAR and S_DRAIN.
- Reset: state <= S_CLEAR, idx <= 0, ovf/err/drain_done <= 0.
- S_CLEAR: write 0 to mem[idx] each cycle. At idx == DEPTH-1, go to S_IDLE and set idx <= 0. ovf and err are cleared on entry.
- S_IDLE input path: when in_valid is high and in_addr < DEPTH:
  - ce = 0: mem[in_addr] <= in_data.
  - ce = 1: mem[in_addr] <= sat(mem[in_addr] + in_data).
- Saturation: the sum is computed at DATA_W+1 bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; ovf is set when clamping occurs.
- Dropped inputs set err:
  - in_addr >= DEPTH in any state;
  - any in_valid in S_CLEAR or S_DRAIN.
- S_IDLE priority: clear beats out_start.
  - clear -> S_CLEAR, idx = 0.
  - out_start -> S_DRAIN, idx = 0.
  - An in_valid in the same cycle as clear or out_start is still written.
- S_DRAIN:
  - out_valid = 1 and out_data = q(mem[idx]).
  - On out_valid && out_ready: if idx == DEPTH-1, go to S_IDLE and pulse drain_done; otherwise idx++.
  - out_last = (idx == DEPTH-1).
- clear in S_DRAIN aborts the drain: go to S_CLEAR with idx = 0, out_valid drops next cycle, no drain_done.
- out_start outside S_IDLE is ignored. clear in S_CLEAR restarts the sweep at idx 0.
- q(x): x < 0 gives 0; otherwise the low OUT_W bits, or the macro behaviour described under Configuration.

## Timing
- Reset values: out_valid 0, out_last 0, out_data 0, drain_done 0, busy 1, ovf 0, err 0.
- Clear sweep lasts exactly DEPTH cycles. busy drops in the cycle after the idx == DEPTH-1 write; 132 cycles after reset release at defaults.
- Write latency is 1 cycle. Back-to-back accumulates to the same address in consecutive cycles must both take effect.
- A write at edge N is visible to a drain started at edge N (out_data valid from cycle N+1).
- out_start sampled at edge N: out_valid = 1 from cycle N+1 with element 0.
- Full drain takes DEPTH cycles with out_ready held high. drain_done is asserted in the cycle after the final handshake.
- While out_valid && !out_ready, out_data and out_last hold stable.
- Reset mid-operation: the next cycle is the S_CLEAR state with idx 0. out_valid is 0 immediately after the reset edge.

## Configuration
- PSUM_SAT_EN defined: q clamps positive values above 2^OUT_W - 1 to 2^OUT_W - 1.
- PSUM_SAT_EN undefined: q truncates to the low OUT_W bits (e.g. 300 -> 44).
- Negative values map to 0 in both builds.

## Structure
- npu_pkg holds:
  - psum_state_e enum: S_IDLE, S_CLEAR, S_DRAIN;
  - PSUM_DEPTH = 132;
  - PSUM_DATA_W = 24.
- Sub-module psum_relu_q: combinational DATA_W -> OUT_W ReLU/quantise. It contains the PSUM_SAT_EN ifdef.

## Test plan
- Reset, then idle 132 cycles: busy falls at cycle 132. out_start with out_ready = 1 yields 132 zeros, out_last on the 132nd element, drain_done one cycle later.
- Layer accumulate: ce = 0 writes 100 to addr 5, then ce = 1 writes -30 and 200 back-to-back. Drain gives element 5 = 255 with PSUM_SAT_EN, 14 without (270 mod 256).
- Saturation: overwrite addr 0 with 8388600, then accumulate 100 -> entry 8388607 and ovf = 1. Accumulate -9000000 on addr 1 -> entry 0 after ReLU, entry -8388608, ovf stays 1.
- Backpressure: drain with out_ready toggling 1,0,0,1. Data holds during the stall, element count is exactly 132, drain_done is a single pulse.
- Errors: in_valid with in_addr = 140 sets err with no write. in_valid during the drain sets err and the drained data is unchanged. clear resets err and ovf.
- Abort: clear at element 40 of a drain -> out_valid is 0 next cycle, no drain_done, 132-cycle sweep, then a drain returns all zeros.
